// File: rtl/jk_bank_scheduler.sv
// Round-robin scheduler sharing one bank of masked JK flip-flops between N_REQ requesters.
// Each transaction runs IDLE -> GRANT -> APPLY and finishes with a one-cycle ack.
module jk_bank_scheduler #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT_Q = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] req_j,
   input  logic [N_REQ*WIDTH-1:0] req_k,
   input  logic [N_REQ*WIDTH-1:0] req_mask,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       ack,
   output logic [WIDTH-1:0]       q,
   output logic [WIDTH-1:0]       q_bar,
   output logic                   busy
);

   localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {StIdle, StGrant, StApply} state_e;

   state_e            state_q, state_d;
   logic [PtrW-1:0]   win_q, win_d;
   logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic [WIDTH-1:0]  q_q, q_d;
   logic [WIDTH-1:0]  j_q, j_d;
   logic [WIDTH-1:0]  k_q, k_d;
   logic [WIDTH-1:0]  mask_q, mask_d;

   logic [WIDTH-1:0]  j_arr    [N_REQ];
   logic [WIDTH-1:0]  k_arr    [N_REQ];
   logic [WIDTH-1:0]  mask_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign j_arr[g]    = req_j[g*WIDTH +: WIDTH];
      assign k_arr[g]    = req_k[g*WIDTH +: WIDTH];
      assign mask_arr[g] = req_mask[g*WIDTH +: WIDTH];
   end

   logic              found;
   int unsigned       idx;

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      rr_ptr_d = rr_ptr_q;
      gnt_d    = '0;
      ack_d    = '0;
      q_d      = q_q;
      j_d      = j_q;
      k_d      = k_q;
      mask_d   = mask_q;
      found    = 1'b0;
      idx      = 0;

      unique case (state_q)
         StIdle: begin
            // Scan starting at rr_ptr so the most recent winner gets lowest priority.
            for (int unsigned i = 0; i < N_REQ; i++) begin
               idx = (32'(rr_ptr_q) + i) % N_REQ;
               if (!found && req[PtrW'(idx)]) begin
                  found = 1'b1;
                  win_d = PtrW'(idx);
               end
            end
            if (found) begin
               gnt_d[win_d] = 1'b1;
               state_d      = StGrant;
            end
         end
         StGrant: begin
            if (req[win_q]) begin
               j_d     = j_arr[win_q];
               k_d     = k_arr[win_q];
               mask_d  = mask_arr[win_q];
               state_d = StApply;
            end else begin
               state_d = StIdle;
            end
         end
         StApply: begin
            // JK characteristic: q+ = j&~q | ~k&q, limited to masked bits.
            q_d = (mask_q & ((j_q & ~q_q) | (~k_q & q_q))) | (~mask_q & q_q);
            ack_d[win_q] = 1'b1;
            if (32'(win_q) == N_REQ - 1) begin
               rr_ptr_d = '0;
            end else begin
               rr_ptr_d = win_q + 1'b1;
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         win_q    <= '0;
         rr_ptr_q <= '0;
         gnt_q    <= '0;
         ack_q    <= '0;
         q_q      <= INIT_Q;
         j_q      <= '0;
         k_q      <= '0;
         mask_q   <= '0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q    <= gnt_d;
         ack_q    <= ack_d;
         q_q      <= q_d;
         j_q      <= j_d;
         k_q      <= k_d;
         mask_q   <= mask_d;
      end
   end

   assign gnt   = gnt_q;
   assign ack   = ack_q;
   assign q     = q_q;
   assign q_bar = ~q_q;
   assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Self-checking bench for jk_bank_scheduler: directed scenarios plus randomized commands
// checked against a behavioural arbitration/JK model.
module tb_jk_bank_scheduler;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] req_j = '0;
   logic [N*W-1:0] req_k = '0;
   logic [N*W-1:0] req_mask = '0;
   logic [N-1:0]   gnt;
   logic [N-1:0]   ack;
   logic [W-1:0]   q;
   logic [W-1:0]   q_bar;
   logic           busy;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [W-1:0] q_m;
   int           rr_m;

   jk_bank_scheduler #(
      .N_REQ (N),
      .WIDTH (W),
      .INIT_Q('0)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .req_j   (req_j),
      .req_k   (req_k),
      .req_mask(req_mask),
      .gnt     (gnt),
      .ack     (ack),
      .q       (q),
      .q_bar   (q_bar),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input int r, input logic [W-1:0] j, input logic [W-1:0] k,
                          input logic [W-1:0] m);
      req_j[r*W +: W]    = j;
      req_k[r*W +: W]    = k;
      req_mask[r*W +: W] = m;
   endtask

   function automatic logic [W-1:0] jk_ref(input logic [W-1:0] qq, input logic [W-1:0] j,
                                           input logic [W-1:0] k, input logic [W-1:0] m);
      logic [W-1:0] r;
      for (int b = 0; b < W; b++) begin
         if (!m[b]) r[b] = qq[b];
         else begin
            case ({j[b], k[b]})
               2'b00:   r[b] = qq[b];
               2'b01:   r[b] = 1'b0;
               2'b10:   r[b] = 1'b1;
               default: r[b] = ~qq[b];
            endcase
         end
      end
      return r;
   endfunction

   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++) begin
         if (r[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h want 00", q); end
      checks++; if (q_bar !== 8'hFF) begin errors++; $display("FAIL reset_qbar got %h want FF", q_bar); end
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      rst = 1'b0;
      q_m  = 8'h00;
      rr_m = 0;
   endtask

   task automatic test_set();
      set_cmd(0, 8'hFF, 8'h00, 8'h0F);
      req = 4'b0001;
      tick();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL set_gnt got %b want 0001", gnt); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL set_busy got %b want 1", busy); end
      tick();
      checks++; if (gnt !== 4'b0000 || ack !== 4'b0000) begin
         errors++; $display("FAIL set_apply gnt %b ack %b want 0000 0000", gnt, ack);
      end
      tick();
      checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL set_ack got %b want 0001", ack); end
      checks++; if (q !== 8'h0F || q_bar !== 8'hF0) begin
         errors++; $display("FAIL set_q got %h/%h want 0F/F0", q, q_bar);
      end
      req = '0;
      tick();
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL set_ack_pulse got %b want 0000", ack); end
      q_m  = 8'h0F;
      rr_m = 1;
   endtask

   task automatic test_toggle();
      set_cmd(1, 8'hFF, 8'hFF, 8'hFF);
      req = 4'b0010;
      tick(); tick(); tick();
      checks++; if (ack !== 4'b0010 || q !== 8'hF0) begin
         errors++; $display("FAIL toggle ack %b q %h want 0010 F0", ack, q);
      end
      set_cmd(1, 8'h00, 8'hFF, 8'h30);
      req = 4'b0010;
      tick();
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL clear_gnt got %b want 0010", gnt); end
      tick(); tick();
      checks++; if (ack !== 4'b0010 || q !== 8'hC0) begin
         errors++; $display("FAIL clear ack %b q %h want 0010 C0", ack, q);
      end
      req = '0;
      q_m  = 8'hC0;
      rr_m = 2;
   endtask

   task automatic test_round_robin();
      int exp_w;
      int prev_w;
      logic [N-1:0] oh;
      for (int r = 0; r < N; r++) set_cmd(r, 8'hFF, 8'hFF, 8'h00);
      req    = 4'b1111;
      exp_w  = rr_m;
      prev_w = -1;
      for (int n = 0; n < 5; n++) begin
         oh = 4'b0001 << exp_w;
         tick();
         checks++; if (gnt !== oh) begin
            errors++; $display("FAIL rr_gnt%0d got %b want %b", n, gnt, oh);
         end
         checks++; if (prev_w == exp_w) begin
            errors++; $display("FAIL rr_repeat%0d got %0d want different from %0d", n, exp_w, prev_w);
         end
         tick();
         tick();
         checks++; if (ack !== oh || q !== q_m) begin
            errors++; $display("FAIL rr_ack%0d ack %b q %h want %b %h", n, ack, q, oh, q_m);
         end
         if (n == 4) req = '0;
         prev_w = exp_w;
         exp_w  = (exp_w + 1) % N;
      end
      rr_m = exp_w;
   endtask

   task automatic test_abort();
      req = 4'b1000;
      tick();
      checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL abort_gnt got %b want 1000", gnt); end
      req = 4'b0000;
      tick();
      checks++; if (busy !== 1'b0 || gnt !== 4'b0000 || ack !== 4'b0000) begin
         errors++; $display("FAIL abort_idle busy %b gnt %b ack %b want 0 0000 0000", busy, gnt, ack);
      end
      tick();
      checks++; if (ack !== 4'b0000 || q !== q_m) begin
         errors++; $display("FAIL abort_noack ack %b q %h want 0000 %h", ack, q, q_m);
      end
      req = 4'b1111;
      tick();
      checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL abort_next got %b want 1000", gnt); end
      tick();
      tick();
      checks++; if (ack !== 4'b1000 || q !== q_m) begin
         errors++; $display("FAIL abort_done ack %b q %h want 1000 %h", ack, q, q_m);
      end
      req  = '0;
      rr_m = 0;
   endtask

   task automatic test_random();
      logic [N-1:0] rv;
      logic [N-1:0] oh;
      logic [W-1:0] ej, ek, em, exp_q;
      int w;
      bit abort;
      for (int it = 0; it < 60; it++) begin
         rv = N'($urandom_range(1, 15));
         for (int r = 0; r < N; r++) set_cmd(r, W'($urandom), W'($urandom), W'($urandom));
         abort = ($urandom_range(0, 3) == 0);
         w  = pick(rv, rr_m);
         oh = 4'b0001 << w;
         req = rv;
         tick();
         checks++; if (gnt !== oh || busy !== 1'b1) begin
            errors++; $display("FAIL rnd_gnt%0d gnt %b busy %b want %b 1", it, gnt, busy, oh);
         end
         if (abort) begin
            req = rv & ~oh;
            tick();
            checks++; if (busy !== 1'b0 || ack !== 4'b0000 || q !== q_m) begin
               errors++; $display("FAIL rnd_abort%0d busy %b ack %b q %h want 0 0000 %h",
                                  it, busy, ack, q, q_m);
            end
            req = '0;
         end else begin
            ej = req_j[w*W +: W];
            ek = req_k[w*W +: W];
            em = req_mask[w*W +: W];
            exp_q = jk_ref(q_m, ej, ek, em);
            req = N'($urandom) | oh;
            tick();
            // Data must already be captured; scramble it.
            set_cmd(w, W'($urandom), W'($urandom), W'($urandom));
            req = N'($urandom) | oh;
            tick();
            checks++; if (ack !== oh || q !== exp_q || q_bar !== ~exp_q || busy !== 1'b0) begin
               errors++; $display("FAIL rnd_apply%0d ack %b q %h qb %h busy %b want %b %h %h 0",
                                  it, ack, q, q_bar, busy, oh, exp_q, ~exp_q);
            end
            q_m  = exp_q;
            rr_m = (w + 1) % N;
            req  = '0;
         end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      set_cmd(0, 8'hFF, 8'h00, 8'hFF);
      req = 4'b0001;
      if (q_m == 8'h00) begin
         // Ensure the command would visibly change q if it were applied.
         q_m = 8'h00;
      end
      tick();
      tick();
      rst = 1'b1;
      tick();
      checks++; if (q !== 8'h00 || ack !== 4'b0000 || busy !== 1'b0 || gnt !== 4'b0000) begin
         errors++; $display("FAIL rstmid q %h ack %b busy %b gnt %b want 00 0000 0 0000",
                            q, ack, busy, gnt);
      end
      rst = 1'b0;
      req = '0;
      tick();
      checks++; if (ack !== 4'b0000 || q !== 8'h00 || q_bar !== 8'hFF) begin
         errors++; $display("FAIL rstmid_after ack %b q %h qb %h want 0000 00 FF", ack, q, q_bar);
      end
      req = 4'b1111;
      tick();
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr got %b want 0001", gnt); end
      req = '0;
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_set();
      test_toggle();
      test_round_robin();
      test_abort();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
